hamming_cost_array: RTL and testbench

//  Pipelined, parametrised successor to the single-pair Hamming unit in origin_cost.
//  Per accepted pixel, computes DISP census-Hamming matching costs at once: cost[d] = popcount(L[x] ^ R[x-d]).

---
 rtl/sgbm_cost_pkg.sv | 24 ++
 rtl/popcount_pipe.sv | 55 +++++
 rtl/hamming_cost_array.sv | 103 ++++++++++
 tb/tb_hamming_cost_array.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sgbm_cost_pkg.sv
// Shared types and helpers for the SGBM matching-cost path: default widths,
// the invalid-cost code, a byte popcount and the lane slice helper.
package sgbm_cost_pkg;

  localparam int DEF_CENSUS_W = 32;
  localparam int DEF_COST_W   = 8;

  localparam logic [DEF_COST_W-1:0] INVALID_COST = '1;

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, b[i]};
    end
    return n;
  endfunction

  // LSB position of lane d in a packed cost vector.
  function automatic int lane_lsb(input int d, input int cost_w);
    return d * cost_w;
  endfunction

endpackage

// File: rtl/popcount_pipe.sv
// One disparity lane: per-byte popcounts (S2), then sum, invalid/clamp and register (S3).
// Optional saturation of valid costs is enabled by defining HAM_CLAMP_EN.
module popcount_pipe
  import sgbm_cost_pkg::*;
#(
  parameter int CENSUS_W   = DEF_CENSUS_W,
  parameter int COST_W     = DEF_COST_W,
  parameter int COST_CLAMP = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CENSUS_W-1:0] xor_in,
  input  logic                inv_in,
  output logic [COST_W-1:0]   cost
);

  localparam int NB = CENSUS_W / 8;
`ifdef HAM_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif
  localparam logic [COST_W-1:0] CLAMP_V = COST_W'(COST_CLAMP);

  logic [NB-1:0][3:0] part_q;
  logic               inv_q;
  logic [COST_W-1:0]  sum;
  logic [COST_W-1:0]  cost_d;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NB; i++) begin
      sum = sum + COST_W'(part_q[i]);
    end
    cost_d = sum;
    if (CLAMP_EN && (sum > CLAMP_V)) cost_d = CLAMP_V;
    if (inv_q) cost_d = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      part_q <= '0;
      inv_q  <= 1'b0;
      cost   <= '0;
    end else if (en) begin
      for (int i = 0; i < NB; i++) begin
        part_q[i] <= popcount8(xor_in[i*8 +: 8]);
      end
      inv_q <= inv_in;
      cost  <= cost_d;
    end
  end

endmodule

// File: rtl/hamming_cost_array.sv
// DISP-lane census Hamming cost array with a right-census window and valid/ready on both sides.
// Owns S1, the window, column tracking and the handshake; HAM_CLAMP_EN enables cost saturation.
module hamming_cost_array
  import sgbm_cost_pkg::*;
#(
  parameter int CENSUS_W   = DEF_CENSUS_W,
  parameter int DISP       = 16,
  parameter int COST_W     = DEF_COST_W,
  parameter int COST_CLAMP = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sol,
  input  logic                     in_eol,
  input  logic [CENSUS_W-1:0]      in_left,
  input  logic [CENSUS_W-1:0]      in_right,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_eol,
  output logic [DISP*COST_W-1:0]   out_cost
);

  localparam int CW = $clog2(DISP);

  logic                           en;
  logic [CW-1:0]                  col;
  logic [CW-1:0]                  col_eff;
  logic [CW-1:0]                  col_next;
  logic [DISP-2:0][CENSUS_W-1:0]  win;
  logic [DISP-1:0][CENSUS_W-1:0]  x1_d;
  logic [DISP-1:0][CENSUS_W-1:0]  x1_q;
  logic [DISP-1:0]                inv1_d;
  logic [DISP-1:0]                inv1_q;
  logic                           v1_q, v2_q;
  logic                           eol1_q, eol2_q;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign col_eff  = in_sol ? '0 : col;
  assign col_next = (col_eff == CW'(DISP-1)) ? col_eff : col_eff + 1'b1;

  // Lane d pairs the left word with the right word d pixels back (window before shift).
  always_comb begin
    x1_d   = '0;
    inv1_d = '0;
    x1_d[0] = in_left ^ in_right;
    for (int d = 1; d < DISP; d++) begin
      x1_d[d] = in_left ^ win[d-1];
    end
    for (int d = 0; d < DISP; d++) begin
      inv1_d[d] = CW'(d) > col_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      win       <= '0;
      x1_q      <= '0;
      inv1_q    <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      eol1_q    <= 1'b0;
      eol2_q    <= 1'b0;
      out_eol   <= 1'b0;
    end else if (en) begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      out_valid <= v2_q;
      eol1_q    <= in_valid && in_eol;
      eol2_q    <= eol1_q;
      out_eol   <= eol2_q;
      x1_q      <= x1_d;
      inv1_q    <= inv1_d;
      if (in_valid) begin
        win[0] <= in_right;
        for (int k = 1; k < DISP-1; k++) begin
          win[k] <= win[k-1];
        end
        col <= col_next;
      end
    end
  end

  for (genvar d = 0; d < DISP; d++) begin : g_lane
    popcount_pipe #(
      .CENSUS_W  (CENSUS_W),
      .COST_W    (COST_W),
      .COST_CLAMP(COST_CLAMP)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .xor_in(x1_q[d]),
      .inv_in(inv1_q[d]),
      .cost  (out_cost[lane_lsb(d, COST_W) +: COST_W])
    );
  end

endmodule

// File: tb/tb_hamming_cost_array.sv
// Self-checking bench for hamming_cost_array (DISP=4, CENSUS_W=32, COST_W=8, COST_CLAMP=20).
// Directed vector table plus random stream with backpressure, checked through a scoreboard queue.
module tb_hamming_cost_array;

  localparam int DISP  = 4;
  localparam int CLAMP = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sol, in_eol;
  logic [31:0] in_left, in_right;
  logic        out_valid, out_ready, out_eol;
  logic [31:0] out_cost;

  hamming_cost_array #(.CENSUS_W(32), .DISP(DISP), .COST_W(8), .COST_CLAMP(CLAMP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sol(in_sol), .in_eol(in_eol),
    .in_left(in_left), .in_right(in_right),
    .out_valid(out_valid), .out_ready(out_ready), .out_eol(out_eol), .out_cost(out_cost)
  );

  always #5 clk = ~clk;

  typedef struct { bit sol; bit eol; logic [31:0] l; logic [31:0] r; logic [31:0] exp; } vec_t;
  typedef struct { logic [31:0] cost; logic eol; } exp_t;

  vec_t        tbl[14];
  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] mwin[3];
  int          mcol;

  bit          prev_stall = 1'b0;
  logic [31:0] prev_cost;
  logic        prev_eol;

  task automatic model_reset();
    mcol = 0;
    for (int i = 0; i < 3; i++) mwin[i] = '0;
  endtask

  task automatic model_step(input bit sol, input logic [31:0] l, input logic [31:0] r,
                            output logic [31:0] c);
    int ce;
    int pc;
    logic [31:0] rr;
    ce = sol ? 0 : mcol;
    c = '0;
    for (int d = 0; d < DISP; d++) begin
      if (d == 0) rr = r;
      else rr = mwin[d-1];
      pc = $countones(l ^ rr);
`ifdef HAM_CLAMP_EN
      if (pc > CLAMP) pc = CLAMP;
`endif
      c[d*8 +: 8] = (d > ce) ? 8'hFF : 8'(pc);
    end
    mwin[2] = mwin[1];
    mwin[1] = mwin[0];
    mwin[0] = r;
    mcol = (ce + 1 > DISP - 1) ? DISP - 1 : ce + 1;
  endtask

  // Called at posedge+#1; the expectation is queued once the accept edge is certain.
  task automatic send(input bit sol, input bit eol, input logic [31:0] l, input logic [31:0] r,
                      input bit use_exp, input logic [31:0] exp);
    int g;
    logic [31:0] mc;
    exp_t e;
    in_valid = 1'b1; in_sol = sol; in_eol = eol; in_left = l; in_right = r;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      model_step(sol, l, r, mc);
      e.cost = use_exp ? exp : mc;
      e.eol  = eol;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sbq.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: outstanding=%0d required 0", sbq.size());
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (!out_valid || out_cost !== prev_cost || out_eol !== prev_eol) begin
          n_fail++;
          $display("FAIL hold: valid=%0b cost=%h eol=%0b required valid=1 cost=%h eol=%0b",
                   out_valid, out_cost, out_eol, prev_cost, prev_eol);
        end
      end
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: in_ready=%0b required 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: cost=%h required none", out_cost);
        end else begin
          e = sbq.pop_front();
          if (out_cost !== e.cost || out_eol !== e.eol) begin
            n_fail++;
            $display("FAIL cost: cost=%h eol=%0b required cost=%h eol=%0b",
                     out_cost, out_eol, e.cost, e.eol);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_cost  = out_cost;
      prev_eol   = out_eol;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] ex;
    int base, k;

    // Test 1: single sol pixel
    tbl[0] = '{1'b1, 1'b0, 32'h0000000A, 32'h00000005, 32'hFFFFFF04};
    // Test 2: alternating right words against all-ones left
    tbl[1] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFF20};
    tbl[2] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF2000};
    tbl[3] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'hFF200020};
    tbl[4] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h20002000};
    tbl[5] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00200020};
    // Test 4: R_x has x+1 ones, left = 0; new line starts at x=6, eol at x=5
    for (int x = 0; x < 8; x++) begin
      r = '0;
      for (int i = 0; i <= x; i++) r[i] = 1'b1;
      base = (x < 6) ? 0 : 6;
      k = x - base;
      ex = '0;
      for (int d = 0; d < DISP; d++) ex[d*8 +: 8] = (d > k) ? 8'hFF : 8'(x - d + 1);
      tbl[6+x] = '{(x == 0 || x == 6), (x == 5), 32'h0, r, ex};
    end

    rst = 1'b1; in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0;
    in_left = '0; in_right = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_cost !== 32'h0 || out_eol !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b cost=%h eol=%0b in_ready=%0b required 0 0 0 1",
               out_valid, out_cost, out_eol, in_ready);
    end

    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) send(tbl[i].sol, tbl[i].eol, tbl[i].l, tbl[i].r, 1'b1, tbl[i].exp);
    drain();

    // Test 3: random stream with a 5-cycle stall then random backpressure
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 40; i++) send(i == 0, ($urandom_range(0, 7) == 0), $urandom, $urandom, 1'b0, '0);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk); #1;
          if (c >= 8 && c < 13) out_ready = 1'b0;
          else if (c >= 25) out_ready = ($urandom_range(0, 3) != 0);
          else out_ready = 1'b1;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Test 5: reset with two pixels in flight
    @(posedge clk); #1;
    send(1'b1, 1'b0, 32'h12345678, 32'h0F0F0F0F, 1'b0, '0);
    send(1'b0, 1'b0, 32'hDEADBEEF, 32'h00FF00FF, 1'b0, '0);
    rst = 1'b1;
    sbq.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL aborted_output: valid=%0b required 0", out_valid);
      end
    end
    @(posedge clk); #1;
    send(1'b0, 1'b0, 32'h0000000F, 32'h00000001, 1'b1, 32'hFFFFFF03);
    drain();

    // Test 6: L = ~R gives a full-width popcount on lane 0, clamped when enabled
    @(posedge clk); #1;
`ifdef HAM_CLAMP_EN
    ex = 32'hFFFFFF00 | 32'(CLAMP);
`else
    ex = 32'hFFFFFF20;
`endif
    r = 32'hA5C3_0F96;
    send(1'b1, 1'b1, ~r, r, 1'b1, ex);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
